// File: rtl/load_pkg.sv
// Shared encodings for the load-extend unit: access sizes, FSM states,
// the default memory-wait budget and the alignment rule.
package load_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'd0,
    SZ_HALF    = 2'd1,
    SZ_WORD    = 2'd2,
    SZ_ILLEGAL = 2'd3
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam int TIMEOUT_CYCLES_DEF = 255;

  // A request is illegal when its size code is reserved or when the
  // address does not fall on a boundary of the access size.
  function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
    logic bad;
    case (size_e'(size))
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Picks the addressed byte/halfword lane out of a little-endian read word
// and sign- or zero-extends it to 32 bits. Purely combinational.
module load_extract
  import load_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic zext);
    logic signed [7:0] s;
    s = $signed(b);
    return zext ? {24'd0, b} : 32'(s);
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic zext);
    logic signed [15:0] s;
    s = $signed(h);
    return zext ? {16'd0, h} : 32'(s);
  endfunction

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane select by byte offset, then extension by access size.
  always_comb begin
    byte_lane = word[7:0];
    case (offset)
      2'd0: byte_lane = word[7:0];
      2'd1: byte_lane = word[15:8];
      2'd2: byte_lane = word[23:16];
      2'd3: byte_lane = word[31:24];
      default: byte_lane = word[7:0];
    endcase
    half_lane = offset[1] ? word[31:16] : word[15:0];
    case (size_e'(size))
      SZ_BYTE: result = ext_byte(byte_lane, is_unsigned);
      SZ_HALF: result = ext_half(half_lane, is_unsigned);
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_extend_unit.sv
// Load unit: accepts a byte/half/word load, issues one aligned word read,
// waits for the memory (with a timeout) and returns the extended result.
module load_extend_unit
  import load_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Req,
  input  logic [31:0] MemAdr,
  input  logic [1:0]  NumBits,
  input  logic        Unsigned,
  output logic        MemRdReq,
  output logic [31:0] MemRdAdr,
  input  logic [31:0] MemRdData,
  input  logic        MemRdValid,
  output logic [31:0] Out,
  output logic        OutValid,
  output logic        Busy,
  output logic        Misaligned,
  output logic        Timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         off_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic [31:0]        ext_data;
  logic               start, fault, capture, expire;

  load_extract u_extract (
    .word        (MemRdData),
    .offset      (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (ext_data)
  );

  // Next-state logic; data capture takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    fault   = 1'b0;
    capture = 1'b0;
    expire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Req) begin
          if (is_misaligned(MemAdr[1:0], NumBits)) begin
            fault = 1'b1;
          end else begin
            start   = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (MemRdValid) begin
          capture = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          expire  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (!Rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Wait counter: cleared on entry to WAIT, counts every WAIT cycle.
  always_ff @(posedge Clk) begin
    if (!Rst_n)                cnt_q <= '0;
    else if (start)            cnt_q <= '0;
    else if (state_q == ST_WAIT) cnt_q <= cnt_q + CNT_W'(1);
  end

  // Request latch and memory read port; address held for the whole wait.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      MemRdReq <= 1'b0;
      MemRdAdr <= '0;
      off_q    <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && Req) begin
        off_q  <= MemAdr[1:0];
        size_q <= NumBits;
        uns_q  <= Unsigned;
      end
      if (start) begin
        MemRdReq <= 1'b1;
        MemRdAdr <= {MemAdr[31:2], 2'b00};
      end else if (capture || expire) begin
        MemRdReq <= 1'b0;
      end
    end
  end

  // Result register and one-cycle status strobes.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Out        <= '0;
      OutValid   <= 1'b0;
      Misaligned <= 1'b0;
      Timeout    <= 1'b0;
    end else begin
      OutValid   <= capture;
      Misaligned <= fault;
      Timeout    <= expire;
      if (capture) Out <= ext_data;
    end
  end

  assign Busy = (state_q == ST_WAIT);

endmodule

// File: tb/tb_load_extend_unit.sv
// Scenario bench for load_extend_unit with a queue scoreboard of expected loads.
module tb_load_extend_unit;

  logic        Clk = 1'b0;
  logic        Rst_n, Req, Unsigned, MemRdValid;
  logic [31:0] MemAdr, MemRdData;
  logic [1:0]  NumBits;
  logic        MemRdReq, OutValid, Busy, Misaligned, Timeout;
  logic [31:0] MemRdAdr, Out;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_v;

  load_extend_unit #(.TIMEOUT_CYCLES(255)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .MemAdr(MemAdr), .NumBits(NumBits),
    .Unsigned(Unsigned), .MemRdReq(MemRdReq), .MemRdAdr(MemRdAdr),
    .MemRdData(MemRdData), .MemRdValid(MemRdValid), .Out(Out),
    .OutValid(OutValid), .Busy(Busy), .Misaligned(Misaligned), .Timeout(Timeout)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference extension model built from shifts and masks.
  function automatic logic [31:0] model(input logic [31:0] w, input logic [1:0] off,
                                        input logic [1:0] nb, input logic uns);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    if (nb == 2'd0) return uns ? (sh & 32'hFF) : (sh[7] ? (sh | 32'hFFFF_FF00) : (sh & 32'hFF));
    if (nb == 2'd1) return uns ? (sh & 32'hFFFF) : (sh[15] ? (sh | 32'hFFFF_0000) : (sh & 32'hFFFF));
    return w;
  endfunction

  task automatic tick();
    @(negedge Clk);
  endtask

  // Present one request for one edge; returns at the negedge after acceptance.
  task automatic issue(input logic [31:0] adr, input logic [1:0] nb, input logic uns);
    Req = 1'b1; MemAdr = adr; NumBits = nb; Unsigned = uns;
    tick();
    Req = 1'b0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; Req = 1'b1; MemAdr = 32'h0000_1000; NumBits = 2'd2; Unsigned = 1'b0;
    MemRdData = '0; MemRdValid = 1'b0;
    repeat (3) tick();
    vectors++; if (Out !== 32'h0) begin miscompares++; $display("FAIL reset_out: got %h want 00000000", Out); end
    vectors++; if ({OutValid, MemRdReq, Busy, Misaligned, Timeout} !== 5'b0) begin
      miscompares++; $display("FAIL reset_flags: got %b want 00000", {OutValid, MemRdReq, Busy, Misaligned, Timeout}); end
    vectors++; if (MemRdAdr !== 32'h0) begin miscompares++; $display("FAIL reset_adr: got %h want 00000000", MemRdAdr); end
    Req = 1'b0; Rst_n = 1'b1;
    tick();
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_req_ignored: busy got %b want 0", Busy); end
  endtask

  task automatic test_lb_signed();
    issue(32'h0000_1003, 2'd0, 1'b0);
    vectors++; if (MemRdReq !== 1'b1 || MemRdAdr !== 32'h0000_1000) begin
      miscompares++; $display("FAIL lb_rdreq: got req=%b adr=%h want 1 00001000", MemRdReq, MemRdAdr); end
    MemRdValid = 1'b1; MemRdData = 32'h8012_3456; sb.push_back(32'hFFFF_FF80);
    tick();
    MemRdValid = 1'b0;
    vectors++; if (OutValid !== 1'b1) begin miscompares++; $display("FAIL lb_outvalid: got %b want 1", OutValid); end
    vectors++;
    if (sb.size() == 0) begin miscompares++; $display("FAIL lb_out: scoreboard empty"); end
    else begin exp_v = sb.pop_front(); if (Out !== exp_v) begin miscompares++; $display("FAIL lb_out: got %h want %h", Out, exp_v); end end
    vectors++; if (MemRdReq !== 1'b0 || Busy !== 1'b0) begin
      miscompares++; $display("FAIL lb_release: got req=%b busy=%b want 0 0", MemRdReq, Busy); end
    tick();
    vectors++; if (OutValid !== 1'b0 || Out !== 32'hFFFF_FF80) begin
      miscompares++; $display("FAIL lb_pulse_hold: got v=%b out=%h want 0 ffffff80", OutValid, Out); end
  endtask

  task automatic test_lhu();
    issue(32'h0000_2002, 2'd1, 1'b1);
    MemRdValid = 1'b1; MemRdData = 32'hBEEF_1234; sb.push_back(32'h0000_BEEF);
    tick();
    MemRdValid = 1'b0;
    vectors++;
    if (sb.size() == 0 || OutValid !== 1'b1) begin miscompares++; $display("FAIL lhu_out: valid got %b want 1", OutValid); end
    else begin exp_v = sb.pop_front(); if (Out !== exp_v) begin miscompares++; $display("FAIL lhu_out: got %h want %h", Out, exp_v); end end
  endtask

  task automatic test_back_to_back();
    int busy_n = 0;
    issue(32'h0000_3000, 2'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (Busy === 1'b1) busy_n++;
      vectors++; if (MemRdReq !== 1'b1 || MemRdAdr !== 32'h0000_3000) begin
        miscompares++; $display("FAIL lw_hold: cycle %0d got req=%b adr=%h want 1 00003000", i, MemRdReq, MemRdAdr); end
      if (i == 3) begin MemRdValid = 1'b1; MemRdData = 32'hDEAD_BEEF; sb.push_back(32'hDEAD_BEEF); end
      tick();
    end
    MemRdValid = 1'b0;
    vectors++; if (busy_n != 4 || Busy !== 1'b0) begin
      miscompares++; $display("FAIL lw_busy: got %0d cycles busy_now=%b want 4 0", busy_n, Busy); end
    vectors++;
    if (sb.size() == 0 || OutValid !== 1'b1) begin miscompares++; $display("FAIL lw_out: valid got %b want 1", OutValid); end
    else begin exp_v = sb.pop_front(); if (Out !== exp_v) begin miscompares++; $display("FAIL lw_out: got %h want %h", Out, exp_v); end end
    issue(32'h0000_4001, 2'd0, 1'b1);
    vectors++; if (Busy !== 1'b1 || MemRdAdr !== 32'h0000_4000) begin
      miscompares++; $display("FAIL b2b_accept: got busy=%b adr=%h want 1 00004000", Busy, MemRdAdr); end
    MemRdValid = 1'b1; MemRdData = 32'h1122_3344; sb.push_back(32'h0000_0033);
    tick();
    MemRdValid = 1'b0;
    vectors++;
    if (sb.size() == 0 || OutValid !== 1'b1) begin miscompares++; $display("FAIL b2b_out: valid got %b want 1", OutValid); end
    else begin exp_v = sb.pop_front(); if (Out !== exp_v) begin miscompares++; $display("FAIL b2b_out: got %h want %h", Out, exp_v); end end
    repeat (3) tick();
    vectors++; if (Out !== 32'h0000_0033 || OutValid !== 1'b0) begin
      miscompares++; $display("FAIL out_hold: got %h v=%b want 00000033 0", Out, OutValid); end
  endtask

  task automatic test_misaligned();
    logic [31:0] adrs[3] = '{32'h0000_2001, 32'h0000_2002, 32'h0000_2000};
    logic [1:0]  nbs[3]  = '{2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 3; i++) begin
      issue(adrs[i], nbs[i], 1'b0);
      vectors++; if (Misaligned !== 1'b1 || MemRdReq !== 1'b0 || Busy !== 1'b0) begin
        miscompares++; $display("FAIL misalign_%0d: got mis=%b req=%b busy=%b want 1 0 0", i, Misaligned, MemRdReq, Busy); end
      tick();
      vectors++; if (Misaligned !== 1'b0 || MemRdReq !== 1'b0 || Busy !== 1'b0) begin
        miscompares++; $display("FAIL misalign_pulse_%0d: got mis=%b req=%b busy=%b want 0 0 0", i, Misaligned, MemRdReq, Busy); end
    end
    MemRdValid = 1'b1; MemRdData = 32'hFFFF_FFFF;
    tick();
    MemRdValid = 1'b0;
    tick();
    vectors++; if (OutValid !== 1'b0 || Out !== 32'h0000_0033) begin
      miscompares++; $display("FAIL idle_valid_ignored: got v=%b out=%h want 0 00000033", OutValid, Out); end
  endtask

  task automatic test_timeout();
    int busy_n = 0;
    bit seen = 0;
    issue(32'h0000_5000, 2'd0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      if (Timeout === 1'b1) begin seen = 1; break; end
      if (Busy === 1'b1) busy_n++;
      tick();
    end
    vectors++; if (!seen || busy_n != 255) begin
      miscompares++; $display("FAIL timeout: got seen=%0d busy_cycles=%0d want 1 255", seen, busy_n); end
    vectors++; if (MemRdReq !== 1'b0 || Busy !== 1'b0 || OutValid !== 1'b0 || Out !== 32'h0000_0033) begin
      miscompares++; $display("FAIL timeout_state: got req=%b busy=%b v=%b out=%h want 0 0 0 00000033", MemRdReq, Busy, OutValid, Out); end
    tick();
    vectors++; if (Timeout !== 1'b0) begin miscompares++; $display("FAIL timeout_pulse: got %b want 0", Timeout); end
    issue(32'h0000_6000, 2'd0, 1'b0);
    repeat (254) tick();
    vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL edge_busy: got %b want 1", Busy); end
    MemRdValid = 1'b1; MemRdData = 32'h0000_007F; sb.push_back(model(32'h0000_007F, 2'd0, 2'd0, 1'b0));
    tick();
    MemRdValid = 1'b0;
    vectors++; if (OutValid !== 1'b1 || Timeout !== 1'b0) begin
      miscompares++; $display("FAIL edge_capture_wins: got v=%b to=%b want 1 0", OutValid, Timeout); end
    vectors++;
    if (sb.size() == 0) begin miscompares++; $display("FAIL edge_out: scoreboard empty"); end
    else begin exp_v = sb.pop_front(); if (Out !== exp_v) begin miscompares++; $display("FAIL edge_out: got %h want %h", Out, exp_v); end end
  endtask

  task automatic test_reset_in_wait();
    issue(32'h0000_7000, 2'd2, 1'b0);
    tick();
    Rst_n = 1'b0;
    tick();
    vectors++; if ({Out, MemRdAdr} !== 64'h0 || {OutValid, MemRdReq, Busy, Misaligned, Timeout} !== 5'b0) begin
      miscompares++; $display("FAIL wait_reset: got out=%h adr=%h flags=%b want 0 0 00000", Out, MemRdAdr,
                              {OutValid, MemRdReq, Busy, Misaligned, Timeout}); end
    Rst_n = 1'b1; MemRdValid = 1'b1; MemRdData = 32'hFFFF_FFFF;
    tick();
    MemRdValid = 1'b0;
    tick();
    vectors++; if (OutValid !== 1'b0 || Out !== 32'h0 || Timeout !== 1'b0) begin
      miscompares++; $display("FAIL wait_reset_abandon: got v=%b out=%h to=%b want 0 0 0", OutValid, Out, Timeout); end
  endtask

  task automatic test_random_lanes();
    logic [31:0] adr, data;
    logic [1:0]  nb;
    logic        uns;
    int          dly;
    bit          seen;
    for (int n = 0; n < 10; n++) begin
      nb   = 2'($urandom_range(0, 2));
      uns  = 1'($urandom_range(0, 1));
      adr  = $urandom;
      if (nb == 2'd1) adr[0] = 1'b0;
      if (nb == 2'd2) adr[1:0] = 2'b00;
      data = $urandom;
      dly  = $urandom_range(0, 2);
      issue(adr, nb, uns);
      vectors++; if (MemRdAdr !== {adr[31:2], 2'b00}) begin
        miscompares++; $display("FAIL rand_adr_%0d: got %h want %h", n, MemRdAdr, {adr[31:2], 2'b00}); end
      repeat (dly) tick();
      MemRdValid = 1'b1; MemRdData = data; sb.push_back(model(data, adr[1:0], nb, uns));
      tick();
      MemRdValid = 1'b0;
      seen = (OutValid === 1'b1);
      vectors++;
      if (!seen || sb.size() == 0) begin miscompares++; $display("FAIL rand_out_%0d: valid got %b want 1", n, OutValid); end
      else begin exp_v = sb.pop_front(); if (Out !== exp_v) begin
        miscompares++; $display("FAIL rand_out_%0d: got %h want %h (adr=%h nb=%0d u=%b)", n, Out, exp_v, adr, nb, uns); end end
    end
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL sb_drain: got %0d left want 0", sb.size()); end
  endtask

  initial begin
    Rst_n = 1'b0; Req = 1'b0; MemAdr = '0; NumBits = '0; Unsigned = 1'b0;
    MemRdData = '0; MemRdValid = 1'b0;
    tick();
    test_reset();
    test_lb_signed();
    test_lhu();
    test_back_to_back();
    test_misaligned();
    test_timeout();
    test_reset_in_wait();
    test_random_lanes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
